// File: rtl/square_pipelined.sv
// Pipelined unsigned integer squarer: one shift-add partial product per stage,
// INPUT_BITS stages plus an output register, one result per enabled clock.
module square_pipelined #(
   parameter  int INPUT_BITS  = 8,
   localparam int OUTPUT_BITS = 2 * INPUT_BITS
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   en,
   input  logic                   start,
   input  logic [INPUT_BITS-1:0]  operand,
   output logic                   data_valid,
   output logic [OUTPUT_BITS-1:0] square
);

   logic                   valid_q [INPUT_BITS];
   logic                   valid_d [INPUT_BITS];
   logic [INPUT_BITS-1:0]  op_q    [INPUT_BITS];
   logic [INPUT_BITS-1:0]  op_d    [INPUT_BITS];
   logic [OUTPUT_BITS-1:0] acc_q   [INPUT_BITS];
   logic [OUTPUT_BITS-1:0] acc_d   [INPUT_BITS];

   logic                   data_valid_q;
   logic [OUTPUT_BITS-1:0] square_q;

   // Stage 0 seeds the accumulator with the bit-0 partial product.
   assign valid_d[0] = start;
   assign op_d[0]    = operand;
   assign acc_d[0]   = operand[0] ? OUTPUT_BITS'(operand) : '0;

   // Stage k adds operand * 2^k when bit k is set; the operand travels with it.
   for (genvar k = 1; k < INPUT_BITS; k++) begin : g_stage
      assign valid_d[k] = valid_q[k-1];
      assign op_d[k]    = op_q[k-1];
      assign acc_d[k]   = acc_q[k-1] +
                          (op_q[k-1][k] ? (OUTPUT_BITS'(op_q[k-1]) << k) : '0);
   end

   // NOTE: the datapath arrays are reset too, so an aborted operation can never
   // leak a stale partial sum onto square after reset_n is released.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q      <= '{default: '0};
         op_q         <= '{default: '0};
         acc_q        <= '{default: '0};
         data_valid_q <= 1'b0;
         square_q     <= '0;
      end else if (en) begin
         valid_q      <= valid_d;
         op_q         <= op_d;
         acc_q        <= acc_d;
         data_valid_q <= valid_q[INPUT_BITS-1];
         square_q     <= acc_q[INPUT_BITS-1];
      end
   end

   assign data_valid = data_valid_q;
   assign square     = square_q;

endmodule

// File: doc/square_pipelined.md
Name: square_pipelined

Overview:
- Fixed-point pipelined integer squarer; the inverse of the team's pipelined square-root unit.
- Accepts one unsigned operand per clock and returns its exact square. Throughput is one result per cycle.
- Pipeline depth scales with operand width.
- Used to generate test radicands for, and check results from, the sqrt pipeline; also usable in the datapath wherever x^2 is needed.

Parameters:
- INPUT_BITS, 8, operand width in bits; any integer >= 1.
- OUTPUT_BITS, 2*INPUT_BITS, result width. Derived; must not be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous reset, active-low.
- en  input  1  pipeline advance enable. When 0, every register holds.
- start  input  1  marks the operand on this cycle as valid.
- operand  input  INPUT_BITS  unsigned value to square.
- data_valid  output  1  registered; high when square carries the result of a start-tagged operand.
- square  output  OUTPUT_BITS  registered unsigned result, operand*operand.

Behaviour:
- Reset: reset_n low asynchronously clears all stage registers, data_valid=0 and square=0. In-flight operations are discarded; no result for them ever appears.
- Structure: INPUT_BITS shift-add stages, then one output register.
- Each stage k holds three registers: valid_k, op_k (INPUT_BITS) and acc_k (OUTPUT_BITS).
- Stage 0, on a rising edge with en=1:
  - valid_0 <= start
  - op_0 <= operand
  - acc_0 <= operand[0] ? operand : 0
- Stage k (1..INPUT_BITS-1), on a rising edge with en=1:
  - valid_k <= valid_(k-1)
  - op_k <= op_(k-1)
  - acc_k <= acc_(k-1) + (op_(k-1)[k] ? (op_(k-1) << k) : 0)
- Output register, on a rising edge with en=1:
  - data_valid <= valid_(INPUT_BITS-1)
  - square <= acc_(INPUT_BITS-1)
- Latency: operand presented before rising edge n (with en=1 on every edge) appears on square after edge n+INPUT_BITS. This is INPUT_BITS+1 cycles (9 at default).
- Data and valid: the datapath computes every cycle regardless of start; start only tags the result.
  - square updates every enabled cycle, including untagged ones.
  - Consumers qualify square with data_valid.
- Arithmetic:
  - All additions are performed at OUTPUT_BITS width.
  - Overflow cannot occur: the maximum result is (2^INPUT_BITS-1)^2 < 2^OUTPUT_BITS.
  - The result is exact; no rounding.
  - Truncating low-order acc bits that are already final is permitted, provided outputs stay bit-identical.
- en=0 stalls the whole pipeline, including data_valid and square. On return to en=1, ordering and values are preserved with no loss or duplication. en has no effect while reset_n is low.
- INPUT_BITS=1: no shift-add stages beyond stage 0; latency 2; square = operand.
- Back-to-back: consecutive start pulses produce consecutive data_valid pulses with no bubbles, in input order.

Test Plan:
- Reset/idle: hold reset_n=0 for 3 cycles, then release with start=0 and operand=0 -> data_valid=0 and square=0 on every cycle.
- Single op: INPUT_BITS=8, operand=0xFF with start for 1 cycle -> exactly 9 cycles later data_valid=1 for one cycle and square=0xFE01; also operand=0 gives 0x0000 and operand=1 gives 0x0001.
- Stream and round trip:
  - Drive operands 0..255 on consecutive cycles with start=1 -> 256 contiguous valid results 0,1,4,...,0xFE01 in order.
  - Feed each result into the sqrt pipeline (INPUT_BITS=16) -> the root equals the original operand.
- Stall: start operands 3,5,7 back-to-back; hold en=0 for 4 cycles mid-flight -> outputs frozen during the stall; afterwards 9, 25, 49 arrive in order, each valid exactly once.
- Reset mid-operation: launch 4 tagged ops, assert reset_n low asynchronously (between edges) 3 cycles later -> data_valid and square drop to 0 immediately; no pre-reset result appears after release.
- Widths: INPUT_BITS=1 with operand 1 -> square=1 after 2 cycles. INPUT_BITS=5, operand=31 -> square=961 after 6 cycles. Random 10k-vector compare against a reference model for INPUT_BITS=13.
